// File: rtl/id_issue_stage.sv
// ID/issue stage: register file with bypassed write-back, per-register
// pending-write scoreboard for RAW hazards, and a valid/ready ID/EX register.
module id_issue_stage #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NUM_WB    = 2,
  parameter int PAYLOAD_W = 128,
  parameter int SB_CNT_W  = 2,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     id_valid_i,
  output logic                     id_ready_o,
  input  logic [AW-1:0]            id_rs1_addr_i,
  input  logic [AW-1:0]            id_rs2_addr_i,
  input  logic                     id_rs1_used_i,
  input  logic                     id_rs2_used_i,
  input  logic [AW-1:0]            id_rd_addr_i,
  input  logic                     id_rd_wr_en_i,
  input  logic [PAYLOAD_W-1:0]     id_payload_i,
  input  logic [NUM_WB-1:0]        wb_we_i,
  input  logic [NUM_WB*AW-1:0]     wb_waddr_i,
  input  logic [NUM_WB*XLEN-1:0]   wb_wdata_i,
  output logic                     ex_valid_o,
  input  logic                     ex_ready_i,
  output logic [XLEN-1:0]          ex_rs1_rdata_o,
  output logic [XLEN-1:0]          ex_rs2_rdata_o,
  output logic [AW-1:0]            ex_rd_addr_o,
  output logic                     ex_rd_wr_en_o,
  output logic [PAYLOAD_W-1:0]     ex_payload_o,
  output logic [31:0]              stall_cnt_o,
  output logic                     sb_err_o
);

  localparam int SB_MAX = (2 ** SB_CNT_W) - 1;

  logic [XLEN-1:0]     r_regs     [NREGS];
  logic [SB_CNT_W-1:0] r_pend     [NREGS];
  logic [SB_CNT_W-1:0] w_pend_nxt [NREGS];
  int                  w_dec      [NREGS];
  int                  w_net;
  logic                w_err_nxt;
  logic                r_sb_err;
  logic [31:0]         r_stall_cnt;

  logic                r_ex_valid;
  logic [XLEN-1:0]     r_ex_rs1;
  logic [XLEN-1:0]     r_ex_rs2;
  logic [AW-1:0]       r_ex_rd;
  logic                r_ex_rd_wr_en;
  logic [PAYLOAD_W-1:0] r_ex_payload;

  logic [XLEN-1:0]     w_rs1_data;
  logic [XLEN-1:0]     w_rs2_data;
  logic                w_haz_rs1;
  logic                w_haz_rs2;
  logic                w_hazard;
  logic                w_sat;
  logic                w_issue;
  logic                w_kill;

  // Count how many write-back ports retire a pending write to each register.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      w_dec[r] = 0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (r != 0 && wb_we_i[k] && wb_waddr_i[k*AW +: AW] == AW'(r))
          w_dec[r] = w_dec[r] + 1;
      end
    end
  end

  // Operand read with same-cycle bypass; the highest-index port wins.
  always_comb begin
    w_rs1_data = r_regs[id_rs1_addr_i];
    w_rs2_data = r_regs[id_rs2_addr_i];
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_we_i[k] && wb_waddr_i[k*AW +: AW] == id_rs1_addr_i)
        w_rs1_data = wb_wdata_i[k*XLEN +: XLEN];
      if (wb_we_i[k] && wb_waddr_i[k*AW +: AW] == id_rs2_addr_i)
        w_rs2_data = wb_wdata_i[k*XLEN +: XLEN];
    end
    if (id_rs1_addr_i == '0) w_rs1_data = '0;
    if (id_rs2_addr_i == '0) w_rs2_data = '0;
  end

  // A source is blocked while writes remain pending after this cycle's write-backs.
  assign w_haz_rs1 = id_rs1_used_i && (id_rs1_addr_i != '0) &&
                     (int'(r_pend[id_rs1_addr_i]) > w_dec[id_rs1_addr_i]);
  assign w_haz_rs2 = id_rs2_used_i && (id_rs2_addr_i != '0) &&
                     (int'(r_pend[id_rs2_addr_i]) > w_dec[id_rs2_addr_i]);
  assign w_hazard  = w_haz_rs1 || w_haz_rs2;
  assign w_sat     = id_rd_wr_en_i && (id_rd_addr_i != '0) &&
                     ((int'(r_pend[id_rd_addr_i]) - w_dec[id_rd_addr_i]) == SB_MAX);

  assign id_ready_o = !rst_i && !flush_i && !w_hazard && !w_sat &&
                      (!r_ex_valid || ex_ready_i);
  assign w_issue    = id_valid_i && id_ready_o;
  assign w_kill     = flush_i && r_ex_valid && r_ex_rd_wr_en && (r_ex_rd != '0);

  // Net scoreboard update: issue increments, write-back and flush decrement, floored at 0.
  always_comb begin
    w_err_nxt = 1'b0;
    w_net     = 0;
    for (int r = 0; r < NREGS; r++) begin
      w_pend_nxt[r] = '0;
      if (r != 0) begin
        w_net = int'(r_pend[r]) - w_dec[r];
        if (w_issue && id_rd_wr_en_i && id_rd_addr_i == AW'(r)) w_net = w_net + 1;
        if (w_kill && r_ex_rd == AW'(r)) w_net = w_net - 1;
        if (w_net < 0) w_err_nxt = 1'b1;
        else           w_pend_nxt[r] = w_net[SB_CNT_W-1:0];
      end
    end
  end

  // Register file write; later ports override earlier ones to the same register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_we_i[k] && wb_waddr_i[k*AW +: AW] != '0)
          r_regs[wb_waddr_i[k*AW +: AW]] <= wb_wdata_i[k*XLEN +: XLEN];
      end
    end
  end

  // Scoreboard counters and sticky underflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS; r++) r_pend[r] <= '0;
      r_sb_err <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_err_nxt) r_sb_err <= 1'b1;
    end
  end

  // ID/EX pipeline register with hold under back-pressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ex_valid    <= 1'b0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_rd_wr_en <= 1'b0;
      r_ex_payload  <= '0;
    end else if (flush_i) begin
      r_ex_valid <= 1'b0;
    end else if (w_issue) begin
      r_ex_valid    <= 1'b1;
      r_ex_rs1      <= w_rs1_data;
      r_ex_rs2      <= w_rs2_data;
      r_ex_rd       <= id_rd_addr_i;
      r_ex_rd_wr_en <= id_rd_wr_en_i;
      r_ex_payload  <= id_payload_i;
    end else if (ex_ready_i) begin
      r_ex_valid <= 1'b0;
    end
  end

  // Hazard-stall cycle counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_stall_cnt <= '0;
    else if (id_valid_i && !id_ready_o && (w_hazard || w_sat) && !flush_i)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign ex_valid_o     = r_ex_valid;
  assign ex_rs1_rdata_o = r_ex_rs1;
  assign ex_rs2_rdata_o = r_ex_rs2;
  assign ex_rd_addr_o   = r_ex_rd;
  assign ex_rd_wr_en_o  = r_ex_rd_wr_en;
  assign ex_payload_o   = r_ex_payload;
  assign stall_cnt_o    = r_stall_cnt;
  assign sb_err_o       = r_sb_err;

endmodule
